// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and HI/LO sequencer types.
// Imported by the HI/LO sequencer and by the instruction decoder.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } hilo_state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } hilo_op_t;

endpackage

// File: rtl/hilo_sign_fix.sv
// Conditional two's-complement negation of a HI/LO pair, either as two
// independent words or as one double-width value (product correction).
module hilo_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             joint,
  input  logic             neg_hi,
  input  logic             neg_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2*WIDTH-1:0] wide_neg;

  assign wide_neg = -{hi_in, lo_in};

  // In joint mode neg_lo alone selects negation of the full double word.
  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    if (joint) begin
      if (neg_lo) begin
        {hi_out, lo_out} = wide_neg;
      end
    end else begin
      if (neg_hi) hi_out = -hi_in;
      if (neg_lo) lo_out = -lo_in;
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; stalls
// decode when HI/LO are read or rewritten while an operation is in flight.
//
// state  | meaning
// IDLE   | waiting for a HI/LO write; latches operand magnitudes and signs
// CALC   | one shift-add or restoring-divide step per cycle, WIDTH steps
// FINISH | sign-correct the result and write HI/LO
module hilo_muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             using_HI_LO,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(WIDTH - 1);

  hilo_state_t          state_q, state_d;
  hilo_op_t             op_q;
  logic [COUNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 neg_hi_q, neg_lo_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 valid_funct, is_signed, is_div, accept;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     res_hi, res_lo;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shl;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   acc_step;

  assign valid_funct = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                       (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign is_signed   = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign is_div      = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign sign_a      = is_signed & operand_a[WIDTH-1];
  assign sign_b      = is_signed & operand_b[WIDTH-1];
  assign accept      = (state_q == IDLE) && start && valid_funct;

  hilo_sign_fix #(.WIDTH(WIDTH)) u_mag (
    .hi_in  (operand_a),
    .lo_in  (operand_b),
    .joint  (1'b0),
    .neg_hi (sign_a),
    .neg_lo (sign_b),
    .hi_out (mag_a),
    .lo_out (mag_b)
  );

  hilo_sign_fix #(.WIDTH(WIDTH)) u_result (
    .hi_in  (acc_q[2*WIDTH-1:WIDTH]),
    .lo_in  (acc_q[WIDTH-1:0]),
    .joint  (op_q == OP_MULT),
    .neg_hi (neg_hi_q),
    .neg_lo (neg_lo_q),
    .hi_out (res_hi),
    .lo_out (res_lo)
  );

  // Multiply keeps the multiplier in the low half; divide keeps the quotient
  // there and the partial remainder in the high half.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = {1'b0, div_shl} - {2'b00, opnd_q};
    acc_step  = acc_q;
    if (op_q == OP_MULT) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_trial[WIDTH+1]) begin
      acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (count_q == LAST_STEP) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_MULT;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q     <= is_div ? OP_DIV : OP_MULT;
            count_q  <= '0;
            acc_q    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_q   <= is_div ? mag_b : mag_a;
            neg_lo_q <= sign_a ^ sign_b;
            neg_hi_q <= is_div ? sign_a : (sign_a ^ sign_b);
          end
        end
        CALC: begin
          acc_q   <= acc_step;
          count_q <= count_q + 1'b1;
        end
        FINISH: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | using_HI_LO);
  assign done  = done_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Scoreboard bench for hilo_muldiv_sequencer: directed vectors push expected
// HI/LO pairs; a monitor pops and compares on every done pulse.
module tb_hilo_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         using_hi_lo = 1'b0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  hilo_muldiv_sequencer #(.WIDTH(W), .COUNT_W(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .funct       (funct),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .using_HI_LO (using_hi_lo),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .HI          (hi),
    .LO          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input string name, input logic [W-1:0] h, input logic [W-1:0] l);
    exp_t e;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: scoreboard empty, HI=%h LO=%h", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
      end
    end
  end

  // Returns with time at #1 after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    start     = 1'b1;
    funct     = f;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
  endtask

  logic [5:0]   t_f  [5] = '{F_MULT, F_DIV, F_DIVU, F_DIV, F_DIVU};
  logic [W-1:0] t_a  [5] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
  logic [W-1:0] t_b  [5] = '{32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
  logic [W-1:0] t_hi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5};
  logic [W-1:0] t_lo [5] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
  string        t_nm [5] = '{"mult_m3x7", "div_m7d2", "divu_100d7", "div_ovf", "divu_div0"};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, bad;

    #2;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;

    // Full-scale unsigned multiply with latency and busy-width checks.
    push("multu_max", 32'hFFFFFFFE, 32'h00000001);
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 60, lat, bc);
    check("multu_latency", lat, 34);
    check("multu_busy_cycles", bc, 33);
    @(negedge clk);
    check("done_single_cycle", done, 0);

    for (int i = 0; i < 5; i++) begin
      push(t_nm[i], t_hi[i], t_lo[i]);
      issue(t_f[i], t_a[i], t_b[i]);
      wait_done(t_nm[i], 60, lat, bc);
      check({t_nm[i], "_latency"}, lat, 34);
    end

    // MFHI arriving three cycles into a multiply holds until the done cycle.
    push("mult_6x7", 32'd0, 32'd42);
    issue(F_MULT, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    using_hi_lo = 1'b1;
    bad = 0;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!stall) bad++;
    end
    check("mfhi_stall_until_done", bad, 0);
    check("mfhi_done_seen", (lat >= 0), 1);
    check("mfhi_no_stall_in_done", stall, 0);
    using_hi_lo = 1'b0;

    // Second multiply issued while busy is held off, then accepted in IDLE.
    push("mult_first", 32'd0, 32'd42);
    push("mult_second", 32'd3, 32'd0);
    issue(F_MULT, 32'd6, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    start     = 1'b1;
    funct     = F_MULT;
    operand_a = 32'h00010000;
    operand_b = 32'h00030000;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (!stall) bad++;
    end
    check("held_start_stalls", bad, 0);
    check("held_start_no_stall_idle", stall, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("held_start_accepted", busy, 1);
    wait_done("mult_second", 60, lat, bc);
    check("mult_second_latency", lat, 33);

    // Asynchronous reset in the middle of CALC.
    issue(F_MULTU, 32'h12345678, 32'd3);
    using_hi_lo = 1'b1;
    repeat (9) @(posedge clk);
    #3;
    check("pre_reset_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    check("midreset_stall", stall, 0);
    check("midreset_done", done, 0);
    #3;
    reset_n     = 1'b1;
    using_hi_lo = 1'b0;
    push("multu_after_reset", 32'd1, 32'h23456780);
    issue(F_MULTU, 32'h12345678, 32'h10);
    wait_done("multu_after_reset", 60, lat, bc);
    check("after_reset_latency", lat, 34);

    // Non-HI/LO funct with start is ignored.
    issue(F_ADD, 32'd1, 32'd2);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) bad++;
    end
    check("add_ignored_busy", bad, 0);
    check("add_ignored_hi", hi, 32'd1);
    check("add_ignored_lo", lo, 32'h23456780);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
